// File: rtl/multiword_add_sequencer.sv
// multiword_add_sequencer: runs a W-bit add/subtract through one 4-bit slice, one nibble per clock, LSB first.
module multiword_add_sequencer #(
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [4*WORDS-1:0]   a,
  input  logic [4*WORDS-1:0]   b,
  input  logic                 sub,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [4*WORDS-1:0]   sum,
  output logic                 carryout,
  output logic                 overflow,
  output logic                 busy
);
  localparam int W  = 4 * WORDS;
  localparam int IW = $clog2(WORDS);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [IW-1:0] idx_q, idx_d;
  logic carry_q, carry_d, co_q, co_d, ov_q, ov_d;
  logic [4:0] slice;
  logic last;
  // b_q already holds ~b for subtract, so the slice only ever adds.
  assign slice = {1'b0, a_q[{idx_q, 2'b00} +: 4]} + {1'b0, b_q[{idx_q, 2'b00} +: 4]} + {4'd0, carry_q};
  assign last = idx_q == IW'(WORDS - 1);
  assign req_ready = state_q == IDLE;
  assign rsp_valid = state_q == DONE;
  assign busy = state_q == RUN;
  assign sum = sum_q;
  assign carryout = co_q;
  assign overflow = ov_q;
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    sum_d = sum_q;
    idx_d = idx_q;
    carry_d = carry_q;
    co_d = co_q;
    ov_d = ov_q;
    unique case (state_q)
      IDLE: if (req_valid) begin
        state_d = RUN;
        a_d = a;
        b_d = sub ? ~b : b;
        carry_d = sub;
        idx_d = '0;
        sum_d = '0;
      end
      RUN: begin
        sum_d[{idx_q, 2'b00} +: 4] = slice[3:0];
        carry_d = slice[4];
        idx_d = idx_q + 1'b1;
        if (last) begin
          state_d = DONE;
          co_d = slice[4];
          ov_d = (a_q[W-1] == b_q[W-1]) && (slice[3] != a_q[W-1]);
        end
      end
      DONE: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      sum_q <= '0;
      idx_q <= '0;
      carry_q <= 1'b0;
      co_q <= 1'b0;
      ov_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      sum_q <= sum_d;
      idx_q <= idx_d;
      carry_q <= carry_d;
      co_q <= co_d;
      ov_q <= ov_d;
    end
  end
endmodule

// File: tb/tb_multiword_add_sequencer.sv
// tb_multiword_add_sequencer: scoreboard bench with random and directed add/subtract requests.
module tb_multiword_add_sequencer;
  localparam int WORDS = 4;
  localparam int W = 4 * WORDS;
  logic clk = 1'b0, reset = 1'b1, req_valid = 1'b0, sub = 1'b0, rsp_ready = 1'b1;
  logic [W-1:0] a = '0, b = '0;
  logic req_ready, rsp_valid, carryout, overflow, busy;
  logic [W-1:0] sum;
  int vectors = 0, miscompares = 0;
  logic [W+1:0] exp_q[$];
  logic [W+1:0] mon_e;
  multiword_add_sequencer #(.WORDS(WORDS)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .a(a), .b(b), .sub(sub), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .sum(sum), .carryout(carryout), .overflow(overflow), .busy(busy)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, need completion");
    $fatal(1);
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask
  // Reference: plain unsigned/signed integer arithmetic on the full operands; returns {carry, overflow, sum}.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    longint ux = longint'(x);
    longint uy = longint'(y);
    longint sx = $signed(x);
    longint sy = $signed(y);
    longint lim = longint'(1) << (W - 1);
    longint r;
    logic [W-1:0] sm;
    logic co, ov;
    if (s) begin
      sm = x - y;
      co = ux >= uy;
      r = sx - sy;
    end else begin
      sm = x + y;
      co = (ux + uy) >= (longint'(1) << W);
      r = sx + sy;
    end
    ov = (r >= lim) || (r < -lim);
    return {co, ov, sm};
  endfunction
  always @(negedge clk) begin
    if (!reset && rsp_valid && rsp_ready) begin
      chk("rsp_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("sum", 32'(sum), 32'(mon_e[W-1:0]));
        chk("carryout", 32'(carryout), 32'(mon_e[W+1]));
        chk("overflow", 32'(overflow), 32'(mon_e[W]));
      end
    end
  end
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_sum"}, 32'(sum), 0);
    chk({tag, "_carryout"}, 32'(carryout), 0);
    chk({tag, "_overflow"}, 32'(overflow), 0);
  endtask
  task automatic wait_latency();
    int n = 0;
    while (!rsp_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", 32'(n), 32'(WORDS));
  endtask
  task automatic wait_idle();
    int n = 0;
    while (rsp_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("rsp_drain", 32'(rsp_valid), 0);
  endtask
  task automatic do_txn(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic ts, input int hold);
    int n = 0;
    @(negedge clk);
    a = ta;
    b = tb_;
    sub = ts;
    req_valid = 1'b1;
    rsp_ready = (hold == 0);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready", 32'(req_ready), 1);
    @(posedge clk);
    exp_q.push_back(model(ta, tb_, ts));
    #1;
    req_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    sub = 1'($urandom);
    chk("busy", 32'(busy), 1);
    wait_latency();
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1;
      rsp_ready = 1'b1;
    end
    wait_idle();
  endtask
  logic [W-1:0] dir_a[6] = '{16'h0004, 16'h7FFF, 16'h8000, 16'h0003, 16'h8000, 16'hFFFF};
  logic [W-1:0] dir_b[6] = '{16'hFFFE, 16'h0001, 16'h8000, 16'h0007, 16'h0001, 16'h0000};
  logic         dir_s[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  initial begin
    logic [W+1:0] e1;
    #12;
    chk_reset_vals("por");
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) do_txn(dir_a[i], dir_b[i], dir_s[i], i % 3);
    for (int i = 0; i < 40; i++) do_txn(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    // Mid-simulation asynchronous reset, observed before any clock edge.
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_vals("async_reset");
    #1;
    reset = 1'b0;
    // Backpressure: result held while a different request waits.
    @(negedge clk);
    a = 16'h1111;
    b = 16'h2222;
    sub = 1'b0;
    req_valid = 1'b1;
    rsp_ready = 1'b0;
    @(posedge clk);
    e1 = model(16'h1111, 16'h2222, 1'b0);
    exp_q.push_back(e1);
    #1;
    a = 16'hABCD;
    b = 16'h0101;
    sub = 1'b1;
    wait_latency();
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("bp_sum", 32'(sum), 32'(e1[W-1:0]));
      chk("bp_carryout", 32'(carryout), 32'(e1[W+1]));
      chk("bp_overflow", 32'(overflow), 32'(e1[W]));
      chk("bp_req_ready", 32'(req_ready), 0);
      chk("bp_rsp_valid", 32'(rsp_valid), 1);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_idle_req_ready", 32'(req_ready), 1);
    chk("bp_idle_rsp_valid", 32'(rsp_valid), 0);
    exp_q.push_back(model(16'hABCD, 16'h0101, 1'b1));
    @(posedge clk);
    #1;
    chk("bp_second_busy", 32'(busy), 1);
    req_valid = 1'b0;
    wait_latency();
    wait_idle();
    // Abort mid-RUN: the dropped operation must never respond.
    @(negedge clk);
    a = 16'h1234;
    b = 16'h1111;
    sub = 1'b0;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk_reset_vals("abort");
    exp_q.delete();
    #1;
    reset = 1'b0;
    repeat (WORDS + 2) begin
      @(negedge clk);
      chk("abort_no_rsp", 32'(rsp_valid), 0);
    end
    do_txn(16'h1234, 16'h1111, 1'b0, 0);
    chk("abort_model_sanity", 32'(model(16'h1234, 16'h1111, 1'b0)), 32'h2345);
    repeat (3) @(posedge clk);
    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
